line_draw_ctrl: RTL and testbench
=================================

LINE_DRAW_CTRL -- requirements
Module: line_draw_ctrl

Interface
REQ-001 Parameter: WIDTH, default 10, coordinate and arithmetic width (signed two's complement).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  line request present.
REQ-005 start_ready  output  1  controller can accept a request; high only in IDLE.
REQ-006 x0, y0, x1, y1  input  WIDTH each  line endpoints, sampled at the start handshake.
REQ-007 pix_valid  output  1  pix_x/pix_y hold a valid pixel.
REQ-008 pix_ready  input  1  downstream accepts the pixel.
REQ-009 pix_x, pix_y  output  WIDTH each  pixel coordinate, already un-swapped for steep lines.
REQ-010 pix_last  output  1  qualifies the final pixel of the line.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse in the cycle after the last pixel handshake.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, INIT, DRAW; transitions: IDLE->PRE on start_valid&start_ready; PRE->INIT unconditionally; INIT->DRAW unconditionally; DRAW->IDLE on pix_valid&pix_ready&pix_last; all other cases hold state.
REQ-014 The precompute enable SHALL be high in the IDLE handshake cycle (capturing x0..y1 into the sub-module input registers) and in PRE (capturing its results), and low otherwise, so results stay frozen during DRAW.
REQ-015 In INIT the stepping registers SHALL load: x = x0_out, y = y0_out, xend = x1_out, err = deltax_out >>> 1 (WIDTH+1-bit signed), steep latched.
REQ-016 In DRAW, pix_valid SHALL be 1; pix_x/pix_y = (y,x) if steep else (x,y); pix_last = (x == xend).
REQ-017 On each pix_valid&pix_ready with pix_last=0, the registers SHALL update: x += 1; err' = err - deltay; if err' < 0 then y += ystep and err' += deltax.
REQ-018 When pix_ready=0, pix_x, pix_y, pix_last, and the internal state SHALL hold unchanged.
REQ-019 The first pix_valid SHALL assert exactly 2 cycles after the start handshake edge; with pix_ready held high, the controller SHALL emit one pixel per cycle, deltax+1 pixels in total.
REQ-020 Pixels SHALL be emitted in ascending major-axis order regardless of endpoint order, because endpoint swapping is done by the precompute stage.
REQ-021 A degenerate line (x0==x1, y0==y1) SHALL emit exactly one pixel with pix_last=1.
REQ-022 start_valid while busy SHALL be ignored (start_ready=0); no request is queued.
REQ-023 y overflow and wrap SHALL be modulo 2^WIDTH; callers must keep coordinates in range.

Reset
REQ-024 rst SHALL force IDLE immediately, including mid-line; the partial line is dropped and no done pulse is produced.
REQ-025 Reset values SHALL be: start_ready=1 after reset release (IDLE), all other outputs 0, all stepping registers 0, and the sub-module registers 0.

Structure
REQ-026 The FSM state encoding and WIDTH default SHALL live in a shared package for the graphics pipeline.
REQ-027 The block SHALL instantiate exactly one precomputed_param_reg, sharing clk/rst and driven by the enable of REQ-014; the stepping datapath and FSM are local.

Verification
REQ-028 (0,0)->(3,1), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1); first valid 2 cycles after handshake; last on (3,1); done pulse next cycle.
REQ-029 Reversed (3,1)->(0,0) -> identical pixel sequence to REQ-028.
REQ-030 Steep (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3); negative ystep (0,2)->(2,0) -> (0,2),(1,1),(2,0).
REQ-031 Degenerate (5,5)->(5,5) -> single pixel (5,5), pix_last=1, then IDLE with start_ready=1.
REQ-032 Backpressure with pix_ready toggled 1,0,0,1,... on REQ-028 -> same four pixels, outputs stable while stalled, no drops or duplicates; start_valid during DRAW is ignored.
REQ-033 rst asserted after the 2nd pixel -> next cycle IDLE, all outputs 0 except start_ready=1 after release, no done pulse; a new request (0,0)->(3,1) then completes per REQ-028.

Source files
------------

// File: rtl/line_draw_ctrl_pkg.sv
// Shared definitions for the graphics pipeline line-drawing controller:
// FSM state encoding and the default coordinate width.
package line_draw_ctrl_pkg;

  localparam int DEF_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_INIT = 2'd2,
    ST_DRAW = 2'd3
  } state_e;

endpackage

// File: rtl/line_draw_ctrl_if.sv
// Request and pixel-stream handshake bundle of the line-drawing controller.
// master = requester/pixel consumer, slave = the controller itself.
interface line_draw_ctrl_if #(parameter int WIDTH = line_draw_ctrl_pkg::DEF_WIDTH);
  logic                    start_valid;
  logic                    start_ready;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] x1;
  logic signed [WIDTH-1:0] y1;
  logic                    pix_valid;
  logic                    pix_ready;
  logic signed [WIDTH-1:0] pix_x;
  logic signed [WIDTH-1:0] pix_y;
  logic                    pix_last;
  logic                    busy;
  logic                    done;

  modport master (
    output start_valid, x0, y0, x1, y1, pix_ready,
    input  start_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );

  modport slave (
    input  start_valid, x0, y0, x1, y1, pix_ready,
    output start_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );
endinterface

// File: rtl/line_draw_ctrl_precomputed_param_reg.sv
// Two-stage Bresenham parameter precompute: registers the endpoints, then
// registers steep/swapped endpoints, deltas and y step. Frozen while en=0.
module precomputed_param_reg #(parameter int WIDTH = 10) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  output logic signed [WIDTH-1:0] x0_out,
  output logic signed [WIDTH-1:0] y0_out,
  output logic signed [WIDTH-1:0] x1_out,
  output logic signed [WIDTH:0]   deltax_out,
  output logic signed [WIDTH:0]   deltay_out,
  output logic signed [WIDTH-1:0] ystep_out,
  output logic                    steep_out
);

  localparam logic signed [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic signed [WIDTH:0]   ZERO_E = {(WIDTH+1){1'b0}};
  localparam logic signed [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] MONE_W = {WIDTH{1'b1}};

  logic signed [WIDTH-1:0] x0_r, y0_r, x1_r, y1_r;
  logic signed [WIDTH-1:0] u0_s, v0_s, u1_s, v1_s, su0_s, sv0_s, su1_s, sv1_s;
  logic signed [WIDTH:0]   ddx_s, ddy_s, adx_s, ady_s, du_s, dv_s;
  logic                    steep_s, swap_s;

  // Steepness test, axis swap and endpoint ordering on the captured endpoints
  always_comb begin
    ddx_s   = {x1_r[WIDTH-1], x1_r} - {x0_r[WIDTH-1], x0_r};
    ddy_s   = {y1_r[WIDTH-1], y1_r} - {y0_r[WIDTH-1], y0_r};
    adx_s   = ddx_s[WIDTH] ? -ddx_s : ddx_s;
    ady_s   = ddy_s[WIDTH] ? -ddy_s : ddy_s;
    steep_s = (ady_s > adx_s);
    u0_s    = steep_s ? y0_r : x0_r;
    v0_s    = steep_s ? x0_r : y0_r;
    u1_s    = steep_s ? y1_r : x1_r;
    v1_s    = steep_s ? x1_r : y1_r;
    swap_s  = (u0_s > u1_s);
    su0_s   = swap_s ? u1_s : u0_s;
    sv0_s   = swap_s ? v1_s : v0_s;
    su1_s   = swap_s ? u0_s : u1_s;
    sv1_s   = swap_s ? v0_s : v1_s;
    du_s    = {su1_s[WIDTH-1], su1_s} - {su0_s[WIDTH-1], su0_s};
    dv_s    = {sv1_s[WIDTH-1], sv1_s} - {sv0_s[WIDTH-1], sv0_s};
  end

  // Input capture and result capture, both gated by the shared enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r       <= ZERO_W;
      y0_r       <= ZERO_W;
      x1_r       <= ZERO_W;
      y1_r       <= ZERO_W;
      x0_out     <= ZERO_W;
      y0_out     <= ZERO_W;
      x1_out     <= ZERO_W;
      deltax_out <= ZERO_E;
      deltay_out <= ZERO_E;
      ystep_out  <= ZERO_W;
      steep_out  <= 1'b0;
    end else if (en) begin
      x0_r       <= x0;
      y0_r       <= y0;
      x1_r       <= x1;
      y1_r       <= y1;
      x0_out     <= su0_s;
      y0_out     <= sv0_s;
      x1_out     <= su1_s;
      deltax_out <= du_s;
      deltay_out <= dv_s[WIDTH] ? -dv_s : dv_s;
      ystep_out  <= dv_s[WIDTH] ? MONE_W : ONE_W;
      steep_out  <= steep_s;
    end
  end

endmodule

// File: rtl/line_draw_ctrl.sv
// Bresenham line-drawing controller: accepts a line request, precomputes its
// parameters, then streams one pixel per accepted handshake in major-axis order.
module line_draw_ctrl import line_draw_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  line_draw_ctrl_if.slave  bus
);

  localparam logic signed [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic signed [WIDTH:0]   ZERO_E = {(WIDTH+1){1'b0}};
  localparam logic signed [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_r;
  logic signed [WIDTH-1:0] x_r, y_r, xend_r, pix_x_r, pix_y_r;
  logic signed [WIDTH:0]   err_r;
  logic                    steep_r, start_ready_r, busy_r, done_r, pix_valid_r, pix_last_r;
  logic signed [WIDTH-1:0] x_nxt_s, y_nxt_s;
  logic signed [WIDTH:0]   err_sub_s, err_nxt_s;
  logic                    hs_start_s, hs_pix_s, pre_en_s;
  logic signed [WIDTH-1:0] pc_x0_s, pc_y0_s, pc_x1_s, pc_ystep_s;
  logic signed [WIDTH:0]   pc_dx_s, pc_dy_s;
  logic                    pc_steep_s;

  precomputed_param_reg #(.WIDTH(WIDTH)) u_pre (
    .clk        (clk),
    .rst        (rst),
    .en         (pre_en_s),
    .x0         (bus.x0),
    .y0         (bus.y0),
    .x1         (bus.x1),
    .y1         (bus.y1),
    .x0_out     (pc_x0_s),
    .y0_out     (pc_y0_s),
    .x1_out     (pc_x1_s),
    .deltax_out (pc_dx_s),
    .deltay_out (pc_dy_s),
    .ystep_out  (pc_ystep_s),
    .steep_out  (pc_steep_s)
  );

  // Handshake decode, precompute enable and the next Bresenham step
  always_comb begin
    hs_start_s = (state_r == ST_IDLE) && bus.start_valid;
    hs_pix_s   = pix_valid_r && bus.pix_ready;
    pre_en_s   = hs_start_s || (state_r == ST_PRE);
    x_nxt_s    = x_r + ONE_W;
    err_sub_s  = err_r - pc_dy_s;
    if (err_sub_s[WIDTH]) begin
      y_nxt_s   = y_r + pc_ystep_s;
      err_nxt_s = err_sub_s + pc_dx_s;
    end else begin
      y_nxt_s   = y_r;
      err_nxt_s = err_sub_s;
    end
  end

  // FSM plus stepping registers; pixel outputs are pre-unswapped into registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      x_r           <= ZERO_W;
      y_r           <= ZERO_W;
      xend_r        <= ZERO_W;
      err_r         <= ZERO_E;
      steep_r       <= 1'b0;
      pix_x_r       <= ZERO_W;
      pix_y_r       <= ZERO_W;
      pix_valid_r   <= 1'b0;
      pix_last_r    <= 1'b0;
      start_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_start_s) begin
            state_r       <= ST_PRE;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end
        end
        ST_PRE: state_r <= ST_INIT;
        ST_INIT: begin
          state_r     <= ST_DRAW;
          x_r         <= pc_x0_s;
          y_r         <= pc_y0_s;
          xend_r      <= pc_x1_s;
          err_r       <= pc_dx_s >>> 1'b1;
          steep_r     <= pc_steep_s;
          pix_x_r     <= pc_steep_s ? pc_y0_s : pc_x0_s;
          pix_y_r     <= pc_steep_s ? pc_x0_s : pc_y0_s;
          pix_last_r  <= (pc_x0_s == pc_x1_s);
          pix_valid_r <= 1'b1;
        end
        ST_DRAW: begin
          if (hs_pix_s && pix_last_r) begin
            state_r       <= ST_IDLE;
            pix_valid_r   <= 1'b0;
            pix_last_r    <= 1'b0;
            pix_x_r       <= ZERO_W;
            pix_y_r       <= ZERO_W;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
          end else if (hs_pix_s) begin
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            err_r      <= err_nxt_s;
            pix_x_r    <= steep_r ? y_nxt_s : x_nxt_s;
            pix_y_r    <= steep_r ? x_nxt_s : y_nxt_s;
            pix_last_r <= (x_nxt_s == xend_r);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.pix_valid   = pix_valid_r;
  assign bus.pix_last    = pix_last_r;
  assign bus.pix_x       = pix_x_r;
  assign bus.pix_y       = pix_y_r;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Self-checking bench for line_draw_ctrl: closed-form Bresenham model per line,
// cycle-level handshake expectations, directed and random lines.
module tb_line_draw_ctrl;

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_draw_ctrl_if #(.WIDTH(10)) bus();

  line_draw_ctrl #(.WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  pix_t exp_q[$];
  bit   exp_busy = 1'b0;
  bit   exp_valid = 1'b0;
  bit   exp_done = 1'b0;
  int   lat = 0;
  int   wd = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pixel k along the major axis lies floor-offset ceil((k*dy - dx/2)/dx) on the minor axis.
  function automatic void build(input int ax0, input int ay0, input int ax1, input int ay1);
    int u0, v0, u1, v1, t, dx, dy, h, sgn, num, k;
    bit steep;
    exp_q.delete();
    steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    u0 = steep ? ay0 : ax0;  v0 = steep ? ax0 : ay0;
    u1 = steep ? ay1 : ax1;  v1 = steep ? ax1 : ay1;
    if (u0 > u1) begin
      t = u0; u0 = u1; u1 = t;
      t = v0; v0 = v1; v1 = t;
    end
    dx  = u1 - u0;
    dy  = iabs(v1 - v0);
    sgn = (v1 >= v0) ? 1 : -1;
    h   = dx / 2;
    for (int i = 0; i <= dx; i++) begin
      num = i * dy - h;
      k   = (num > 0) ? (num + dx - 1) / dx : 0;
      if (steep) exp_q.push_back('{x: v0 + sgn * k, y: u0 + i});
      else       exp_q.push_back('{x: u0 + i, y: v0 + sgn * k});
    end
  endfunction

  function automatic void pin(input string nm, input int n,
                              input int ax0, input int ay0, input int ax1, input int ay1,
                              input int ax2, input int ay2, input int ax3, input int ay3);
    int px[4];
    int py[4];
    px = '{ax0, ax1, ax2, ax3};
    py = '{ay0, ay1, ay2, ay3};
    chk({nm, "_len"}, exp_q.size(), n);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({nm, "_x"}, exp_q[i].x, px[i]);
      chk({nm, "_y"}, exp_q[i].y, py[i]);
    end
  endfunction

  // Model pins, then per-cycle comparison of every DUT output against the model
  initial begin
    build(0, 0, 3, 1);  pin("pin_fwd", 4, 0, 0, 1, 0, 2, 1, 3, 1);
    build(3, 1, 0, 0);  pin("pin_rev", 4, 0, 0, 1, 0, 2, 1, 3, 1);
    build(0, 0, 1, 3);  pin("pin_steep", 4, 0, 0, 0, 1, 1, 2, 1, 3);
    build(0, 2, 2, 0);  pin("pin_negy", 3, 0, 2, 1, 1, 2, 0, 0, 0);
    build(5, 5, 5, 5);  pin("pin_degen", 1, 5, 5, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; lat = 0; wd = 0;
        exp_q.delete();
      end
      chk("start_ready", int'(bus.start_ready), exp_busy ? 0 : 1);
      chk("busy", int'(bus.busy), exp_busy ? 1 : 0);
      chk("done", int'(bus.done), exp_done ? 1 : 0);
      chk("pix_valid", int'(bus.pix_valid), exp_valid ? 1 : 0);
      if (exp_valid && exp_q.size() > 0) begin
        chk("pix_x", int'(bus.pix_x), exp_q[0].x);
        chk("pix_y", int'(bus.pix_y), exp_q[0].y);
        chk("pix_last", int'(bus.pix_last), (exp_q.size() == 1) ? 1 : 0);
      end
      if (!rst) begin
        exp_done = 1'b0;
        if (!exp_busy) begin
          if (bus.start_valid) begin
            build(int'(bus.x0), int'(bus.y0), int'(bus.x1), int'(bus.y1));
            exp_busy = 1'b1; lat = 2; wd = 0;
          end
        end else if (!exp_valid) begin
          lat--;
          if (lat == 0) exp_valid = 1'b1;
        end else if (bus.pix_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
          end
        end
        if (exp_busy) begin
          wd++;
          if (wd == 401) chk("watchdog_cycles", wd, 400);
        end
      end
    end
  end

  // mode 0: ready always high; 1: random ready; 2: ready pattern 1,0,0 repeating
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int mode);
    int k;
    @(posedge clk); #1;
    bus.x0 = 10'(ax0); bus.y0 = 10'(ay0); bus.x1 = 10'(ax1); bus.y1 = 10'(ay1);
    bus.start_valid = 1'b1;
    bus.pix_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    k = 0;
    while (bus.busy && k < 500) begin
      if (mode != 0) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.x0 = 10'($urandom_range(0, 60)); bus.y0 = 10'($urandom_range(0, 60));
      end
      case (mode)
        1:       bus.pix_ready = 1'($urandom_range(0, 1));
        2:       bus.pix_ready = (k % 3 == 0);
        default: bus.pix_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      k++;
    end
    bus.start_valid = 1'b0;
    bus.pix_ready   = 1'b1;
  endtask

  // Stimulus sequence
  initial begin
    int cnt, k;
    bus.start_valid = 1'b0;
    bus.pix_ready   = 1'b1;
    bus.x0 = 10'd0; bus.y0 = 10'd0; bus.x1 = 10'd0; bus.y1 = 10'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_line(0, 0, 3, 1, 0);
    run_line(3, 1, 0, 0, 0);
    run_line(0, 0, 1, 3, 0);
    run_line(0, 2, 2, 0, 0);
    run_line(5, 5, 5, 5, 0);
    run_line(0, 0, 3, 1, 2);
    // Reset mid-line after the second pixel handshake
    @(posedge clk); #1;
    bus.x0 = 10'd0; bus.y0 = 10'd0; bus.x1 = 10'd3; bus.y1 = 10'd1;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    cnt = 0; k = 0;
    while (cnt < 2 && k < 50) begin
      if (bus.pix_valid && bus.pix_ready) cnt++;
      @(posedge clk); #1;
      k++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_line(0, 0, 3, 1, 0);
    for (int i = 0; i < 30; i++) begin
      run_line($urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30,
               $urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30, 1 + (i % 2));
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
